// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Included by the FSM top and the storage array.
package mem_responder_pkg;

  // Default data/address width in bits.
  localparam int DEF_WIDTH = 8;

  // The wait counter is sized for WAIT values from 0 to 15.
  localparam int CNT_W = 4;

  // Enum literals carry an ST_ prefix so they do not collide with the WAIT parameter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Byte-wide storage for the responder.
// Provides one synchronous write port and one combinational read port.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  // The contents are deliberately left uninitialised, and reset does not clear them.
  logic [WIDTH-1:0] mem_reg [0:(2**WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for the multicycle MIPS core.
// It captures a request, waits WAIT cycles, then gives a one-cycle memready strobe.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic             memready,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] adr_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic             op_write_reg;
  logic [WIDTH-1:0] memdata_reg;
  logic             memready_reg;
  logic             proto_err_reg;

  logic             capture;
  logic             enter_resp;
  logic             read_next;
  logic             mem_we;
  logic [WIDTH-1:0] mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (memread || memwrite) begin
          capture  = 1'b1;
          cnt_next = WAIT_LD;
          if (WAIT_LD == '0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // With WAIT=0, RESP is entered on the capture edge itself, so the read address and operation come straight from the inputs.
  always_comb begin
    read_next = 1'b0;
    mem_raddr = adr_reg;
    if (state_reg == ST_IDLE) begin
      read_next = !memwrite;
      mem_raddr = adr;
    end else begin
      read_next = !op_write_reg;
    end
  end

  // Writes commit on the edge that leaves RESP. A reset on that edge abandons the write.
  assign mem_we = (state_reg == ST_RESP) && op_write_reg && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      adr_reg       <= '0;
      wdata_reg     <= '0;
      op_write_reg  <= 1'b0;
      memdata_reg   <= '0;
      memready_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      memready_reg <= enter_resp;
      if (capture) begin
        adr_reg      <= adr;
        wdata_reg    <= writedata;
        op_write_reg <= memwrite;
      end
      if (enter_resp && read_next) begin
        memdata_reg <= mem_rdata;
      end
      if ((state_reg == ST_IDLE) && memread && memwrite) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  mem_responder_array #(
    .WIDTH(WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (adr_reg),
    .wdata (wdata_reg),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign memdata   = memdata_reg;
  assign memready  = memready_reg;
  assign proto_err = proto_err_reg;

endmodule
